// File: rtl/bank_req_arbiter_pkg.sv
// rtl/bank_req_arbiter_pkg.sv - shared widths, bank geometry and request types for the bank arbiter
package pkg_2;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 6;
  localparam int NUM_BANKS  = 4;
  localparam int BANK_SEL_W = 2;

  localparam logic [15:0] CONFLICT_CNT_MAX = 16'hFFFF;

  // One memory request as carried through the arbiter at default widths.
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  // Round-robin pointer: names the port that wins the next same-bank conflict.
  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_sel_e;

endpackage

// File: rtl/bank_req_arbiter_port_hold_reg.sv
// rtl/bank_req_arbiter_port_hold_reg.sv - one-entry per-port hold register with ready and candidate selection
module port_hold_reg #(
  parameter int DATA_WIDTH = pkg_2::DATA_WIDTH,
  parameter int ADDR_WIDTH = pkg_2::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic                  issue_i,
  output logic                  cand_valid_o,
  output logic                  cand_we_o,
  output logic [ADDR_WIDTH-1:0] cand_addr_o,
  output logic [DATA_WIDTH-1:0] cand_wdata_o
);

  logic                  hold_valid_q, hold_valid_d;
  logic                  hold_we_q, hold_we_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
  logic                  accept;

  // A port with a parked entry refuses new work, which keeps per-port order intact.
  assign req_ready_o = ~hold_valid_q;
  assign accept      = req_valid_i & ~hold_valid_q;

  // Candidate for this cycle: the parked entry first, otherwise the request being accepted.
  always_comb begin
    cand_valid_o = 1'b0;
    cand_we_o    = req_we_i;
    cand_addr_o  = req_addr_i;
    cand_wdata_o = req_wdata_i;
    if (hold_valid_q) begin
      cand_valid_o = 1'b1;
      cand_we_o    = hold_we_q;
      cand_addr_o  = hold_addr_q;
      cand_wdata_o = hold_wdata_q;
    end else if (accept) begin
      cand_valid_o = 1'b1;
    end
  end

  // Park a freshly accepted request that lost arbitration; free the slot once it issues.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    if (hold_valid_q) begin
      if (issue_i) begin
        hold_valid_d = 1'b0;
      end
    end else if (accept && !issue_i) begin
      hold_valid_d = 1'b1;
      hold_we_d    = req_we_i;
      hold_addr_d  = req_addr_i;
      hold_wdata_d = req_wdata_i;
    end
  end

  // Hold register state; reset discards whatever was parked.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_we_q    <= hold_we_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
    end
  end

endmodule

// File: rtl/bank_req_arbiter.sv
// rtl/bank_req_arbiter.sv - two-port request arbiter onto a 4-bank memory with round-robin conflict resolution
module bank_req_arbiter
  import pkg_2::*;
#(
  parameter int DATA_WIDTH = pkg_2::DATA_WIDTH,
  parameter int ADDR_WIDTH = pkg_2::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_a,
  input  logic                  req_valid_b,
  output logic                  req_ready_a,
  output logic                  req_ready_b,
  input  logic                  req_we_a,
  input  logic                  req_we_b,
  input  logic [ADDR_WIDTH-1:0] req_addr_a,
  input  logic [ADDR_WIDTH-1:0] req_addr_b,
  input  logic [DATA_WIDTH-1:0] req_wdata_a,
  input  logic [DATA_WIDTH-1:0] req_wdata_b,
  output logic                  mem_en_a,
  output logic                  mem_en_b,
  output logic                  mem_we_a,
  output logic                  mem_we_b,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic [DATA_WIDTH-1:0] mem_wdata_a,
  output logic [DATA_WIDTH-1:0] mem_wdata_b,
  output logic [15:0]           conflict_cnt
);

  logic                  cand_valid_a, cand_valid_b;
  logic                  cand_we_a, cand_we_b;
  logic [ADDR_WIDTH-1:0] cand_addr_a, cand_addr_b;
  logic [DATA_WIDTH-1:0] cand_wdata_a, cand_wdata_b;
  logic [BANK_SEL_W-1:0] bank_a, bank_b;
  logic                  conflict;
  logic                  issue_a, issue_b;

  rr_sel_e               rr_ptr_q, rr_ptr_d;
  logic [15:0]           conflict_cnt_q, conflict_cnt_d;

  logic                  mem_en_a_q, mem_en_a_d, mem_en_b_q, mem_en_b_d;
  logic                  mem_we_a_q, mem_we_a_d, mem_we_b_q, mem_we_b_d;
  logic [ADDR_WIDTH-1:0] mem_addr_a_q, mem_addr_a_d, mem_addr_b_q, mem_addr_b_d;
  logic [DATA_WIDTH-1:0] mem_wdata_a_q, mem_wdata_a_d, mem_wdata_b_q, mem_wdata_b_d;

  port_hold_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hold_a (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_a),
    .req_ready_o  (req_ready_a),
    .req_we_i     (req_we_a),
    .req_addr_i   (req_addr_a),
    .req_wdata_i  (req_wdata_a),
    .issue_i      (issue_a),
    .cand_valid_o (cand_valid_a),
    .cand_we_o    (cand_we_a),
    .cand_addr_o  (cand_addr_a),
    .cand_wdata_o (cand_wdata_a)
  );

  port_hold_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hold_b (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_b),
    .req_ready_o  (req_ready_b),
    .req_we_i     (req_we_b),
    .req_addr_i   (req_addr_b),
    .req_wdata_i  (req_wdata_b),
    .issue_i      (issue_b),
    .cand_valid_o (cand_valid_b),
    .cand_we_o    (cand_we_b),
    .cand_addr_o  (cand_addr_b),
    .cand_wdata_o (cand_wdata_b)
  );

  // The bank is selected by the top address bits.
  assign bank_a = cand_addr_a[ADDR_WIDTH-1 -: BANK_SEL_W];
  assign bank_b = cand_addr_b[ADDR_WIDTH-1 -: BANK_SEL_W];

  // Same-bank collisions go to the port named by rr_ptr; the pointer then moves to the loser
  // so a parked request always wins its very next conflict.
  always_comb begin
    conflict       = cand_valid_a & cand_valid_b & (bank_a == bank_b);
    issue_a        = cand_valid_a & (~conflict | (rr_ptr_q == RR_A));
    issue_b        = cand_valid_b & (~conflict | (rr_ptr_q == RR_B));
    rr_ptr_d       = rr_ptr_q;
    conflict_cnt_d = conflict_cnt_q;
    if (conflict) begin
      rr_ptr_d = (rr_ptr_q == RR_A) ? RR_B : RR_A;
      if (conflict_cnt_q != CONFLICT_CNT_MAX) begin
        conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
    end
  end

  // Issued fields are captured only on issue so idle cycles leave the last request visible.
  always_comb begin
    mem_en_a_d    = issue_a;
    mem_we_a_d    = mem_we_a_q;
    mem_addr_a_d  = mem_addr_a_q;
    mem_wdata_a_d = mem_wdata_a_q;
    mem_en_b_d    = issue_b;
    mem_we_b_d    = mem_we_b_q;
    mem_addr_b_d  = mem_addr_b_q;
    mem_wdata_b_d = mem_wdata_b_q;
    if (issue_a) begin
      mem_we_a_d    = cand_we_a;
      mem_addr_a_d  = cand_addr_a;
      mem_wdata_a_d = cand_wdata_a;
    end
    if (issue_b) begin
      mem_we_b_d    = cand_we_b;
      mem_addr_b_d  = cand_addr_b;
      mem_wdata_b_d = cand_wdata_b;
    end
  end

  // Arbiter and memory-side registers; reset drops every in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= RR_A;
      conflict_cnt_q <= '0;
      mem_en_a_q     <= 1'b0;
      mem_we_a_q     <= 1'b0;
      mem_addr_a_q   <= '0;
      mem_wdata_a_q  <= '0;
      mem_en_b_q     <= 1'b0;
      mem_we_b_q     <= 1'b0;
      mem_addr_b_q   <= '0;
      mem_wdata_b_q  <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      conflict_cnt_q <= conflict_cnt_d;
      mem_en_a_q     <= mem_en_a_d;
      mem_we_a_q     <= mem_we_a_d;
      mem_addr_a_q   <= mem_addr_a_d;
      mem_wdata_a_q  <= mem_wdata_a_d;
      mem_en_b_q     <= mem_en_b_d;
      mem_we_b_q     <= mem_we_b_d;
      mem_addr_b_q   <= mem_addr_b_d;
      mem_wdata_b_q  <= mem_wdata_b_d;
    end
  end

  assign mem_en_a     = mem_en_a_q;
  assign mem_we_a     = mem_we_a_q;
  assign mem_addr_a   = mem_addr_a_q;
  assign mem_wdata_a  = mem_wdata_a_q;
  assign mem_en_b     = mem_en_b_q;
  assign mem_we_b     = mem_we_b_q;
  assign mem_addr_b   = mem_addr_b_q;
  assign mem_wdata_b  = mem_wdata_b_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
